// File: rtl/outpkt_arbiter.sv
// Round-robin packet arbiter: grants one source at a time and streams its whole packet to the checksum stage.
// Optional maximum-length enforcement is enabled with `define OUTPKT_ARB_MAXLEN_CHECK_EN.
module outpkt_arbiter #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [16*N_SRC-1:0]   src_din,
  input  logic [N_SRC-1:0]      src_pkt_end,
  input  logic [N_SRC-1:0]      src_empty,
  output logic [N_SRC-1:0]      src_rd_en,
  output logic [15:0]           dout,
  output logic                  pkt_new,
  output logic                  pkt_end,
  output logic                  wr_en,
  input  logic                  full,
  output logic [N_SRC-1:0]      grant,
  output logic                  err
);

  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CW = 16;

  if (N_SRC < 2 || N_SRC > 8 || MAX_WORDS < 2 || MAX_WORDS > 65536) begin : g_bad_params
    $error("outpkt_arbiter: N_SRC must be 2..8 and MAX_WORDS 2..65536");
  end

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N_SRC-1:0]  grant_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     sel_idx;
  logic              found;
  logic              forced;

`ifdef OUTPKT_ARB_MAXLEN_CHECK_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Round-robin search starting one past the last granted source
  always_comb begin
    found   = 1'b0;
    sel_idx = last_q;
    cand    = last_q;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = IW'((32'(last_q) + k) % N_SRC);
      if (!found && !src_empty[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    gidx_d    = gidx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    wr_en     = 1'b0;
    src_rd_en = '0;
    dout      = '0;
    pkt_new   = 1'b0;
    pkt_end   = 1'b0;
    forced    = 1'b0;
`ifdef OUTPKT_ARB_MAXLEN_CHECK_EN
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d          = XFER;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          gidx_d           = sel_idx;
          cnt_d            = '0;
          first_d          = 1'b1;
        end
      end
      XFER: begin
        dout  = src_din[32'(gidx_q)*16 +: 16];
        wr_en = ~src_empty[gidx_q] & ~full;
`ifdef OUTPKT_ARB_MAXLEN_CHECK_EN
        forced = (cnt_q == CW'(MAX_WORDS - 1)) & ~src_pkt_end[gidx_q];
`endif
        pkt_new = wr_en & first_q;
        pkt_end = wr_en & (src_pkt_end[gidx_q] | forced);
        if (wr_en) begin
          src_rd_en[gidx_q] = 1'b1;
          first_d           = 1'b0;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (pkt_end) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = gidx_q;
`ifdef OUTPKT_ARB_MAXLEN_CHECK_EN
            if (forced) begin
              err_d = 1'b1;
            end
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register; last_grant resets to the final source so source 0 wins first
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      grant   <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N_SRC - 1);
      cnt_q   <= '0;
      first_q <= 1'b0;
`ifdef OUTPKT_ARB_MAXLEN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
`ifdef OUTPKT_ARB_MAXLEN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_outpkt_arbiter.sv
// Directed bench for outpkt_arbiter: source FIFO models feed packets, every written word is logged and checked.
module tb_outpkt_arbiter;

  localparam int unsigned NS = 4;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   src_din;
  logic [3:0]    src_pkt_end;
  logic [3:0]    src_empty;
  logic [3:0]    src_rd_en;
  logic [15:0]   dout;
  logic          pkt_new;
  logic          pkt_end;
  logic          wr_en;
  logic          full;
  logic [3:0]    grant;
  logic          err;

  always #5 CLK = ~CLK;

  outpkt_arbiter #(.N_SRC(NS), .MAX_WORDS(8)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .src_din     (src_din),
    .src_pkt_end (src_pkt_end),
    .src_empty   (src_empty),
    .src_rd_en   (src_rd_en),
    .dout        (dout),
    .pkt_new     (pkt_new),
    .pkt_end     (pkt_end),
    .wr_en       (wr_en),
    .full        (full),
    .grant       (grant),
    .err         (err)
  );

  logic [16:0] mem [NS][64];
  int          head [NS];
  int          tail [NS];
  logic [3:0]  hold_empty;

  logic [15:0] log_d [64];
  logic [1:0]  log_f [64];
  logic [3:0]  log_g [64];
  int          log_c [64];
  int          n_log;
  int          cyc;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < NS; s++) begin
      head[s] = 0;
      tail[s] = 0;
    end
  endtask

  task automatic push(input int s, input logic [15:0] w, input logic last);
    if (tail[s] < 64) begin
      mem[s][tail[s]] = {last, w};
      tail[s]++;
    end
  endtask

  task automatic load_pkt(input int s, input logic [15:0] base, input int len);
    for (int k = 0; k < len; k++) push(s, base + 16'(k), k == len - 1);
  endtask

  task automatic apply_inputs();
    logic [16:0] e;
    for (int s = 0; s < NS; s++) begin
      if (head[s] < tail[s]) begin
        e = mem[s][head[s]];
        src_din[s*16 +: 16] = e[15:0];
        src_pkt_end[s]      = e[16];
        src_empty[s]        = hold_empty[s];
      end else begin
        src_din[s*16 +: 16] = 16'h0000;
        src_pkt_end[s]      = 1'b0;
        src_empty[s]        = 1'b1;
      end
    end
  endtask

  // One clock: check outputs at negedge, log writes, pop sources after posedge
  task automatic step();
    logic [3:0] rd;
    logic       exp_wr;
    int         g;
    @(negedge CLK);
    if (grant == 4'b0000) begin
      check("idle_quiet", 32'({wr_en, pkt_new, pkt_end, src_rd_en, dout}), 32'h0);
    end else begin
      g = 0;
      for (int s = 0; s < NS; s++) if (grant[s]) g = s;
      exp_wr = !src_empty[g] && !full;
      check("wr_en", 32'(wr_en), 32'(exp_wr));
      check("rd_en", 32'(src_rd_en), exp_wr ? 32'(grant) : 32'h0);
      check("dout", 32'(dout), 32'(src_din[g*16 +: 16]));
    end
    if (wr_en && n_log < 64) begin
      log_d[n_log] = dout;
      log_f[n_log] = {pkt_new, pkt_end};
      log_g[n_log] = grant;
      log_c[n_log] = cyc;
      n_log++;
    end
    rd = src_rd_en;
    @(posedge CLK);
    #1;
    for (int s = 0; s < NS; s++) if (rd[s] && head[s] < tail[s]) head[s]++;
    cyc++;
    apply_inputs();
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    full       = 1'b0;
    hold_empty = 4'b0000;
    apply_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_wr_flags", 32'({wr_en, pkt_new, pkt_end}), 32'h0);
    check("rst_rd_en", 32'(src_rd_en), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(posedge CLK);
    #1;
    rst   = 1'b0;
    n_log = 0;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_log = 0;
    cyc   = 0;
    full  = 1'b0;
    hold_empty = 4'b0000;
    clear_srcs();

    // Sources 0 and 2 with 6-word packets
    load_pkt(0, 16'h0100, 6);
    load_pkt(2, 16'h0200, 6);
    reset_dut();
    repeat (20) step();
    check("t1_count", 32'(n_log), 32'd12);
    for (int k = 0; k < 6; k++) begin
      check("t1_s0_word", 32'(log_d[k]), 32'h0100 + 32'(k));
      check("t1_s0_grant", 32'(log_g[k]), 32'h1);
      check("t1_s0_flags", 32'(log_f[k]), 32'({k == 0, k == 5}));
      check("t1_s2_word", 32'(log_d[k+6]), 32'h0200 + 32'(k));
      check("t1_s2_grant", 32'(log_g[k+6]), 32'h4);
      check("t1_s2_flags", 32'(log_f[k+6]), 32'({k == 0, k == 5}));
    end
    check("t1_idle_gap", 32'(log_c[6] - log_c[5]), 32'd2);

    // All sources busy, 3-word packets
    clear_srcs();
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < 2; p++)
        load_pkt(s, 16'(32'h1000 * (s + 1) + 32'h100 * p), 3);
    reset_dut();
    repeat (40) step();
    check("t2_count", 32'(n_log), 32'd24);
    for (int p = 0; p < 5; p++)
      check("t2_order", 32'(log_g[3*p]), 32'(4'b0001 << (p % 4)));
    check("t2_wrap_word", 32'(log_d[12]), 32'h1100);

    // full stall mid-packet
    clear_srcs();
    load_pkt(1, 16'h2000, 6);
    reset_dut();
    repeat (3) step();
    full = 1'b1;
    repeat (5) step();
    check("t3_stall_grant", 32'(grant), 32'h2);
    full = 1'b0;
    repeat (8) step();
    check("t3_count", 32'(n_log), 32'd6);
    for (int k = 0; k < 6; k++) begin
      check("t3_word", 32'(log_d[k]), 32'h2000 + 32'(k));
      check("t3_grant", 32'(log_g[k]), 32'h2);
    end
    check("t3_stall_gap", 32'(log_c[2] - log_c[1]), 32'd6);

    // Source 1 runs dry mid-packet while source 3 waits
    clear_srcs();
    load_pkt(1, 16'h4000, 6);
    load_pkt(3, 16'h4300, 4);
    reset_dut();
    repeat (3) step();
    hold_empty = 4'b0010;
    apply_inputs();
    repeat (3) step();
    hold_empty = 4'b0000;
    apply_inputs();
    repeat (16) step();
    check("t4_count", 32'(n_log), 32'd10);
    for (int k = 0; k < 6; k++) begin
      check("t4_s1_word", 32'(log_d[k]), 32'h4000 + 32'(k));
      check("t4_s1_grant", 32'(log_g[k]), 32'h2);
    end
    for (int k = 0; k < 4; k++) begin
      check("t4_s3_word", 32'(log_d[k+6]), 32'h4300 + 32'(k));
      check("t4_s3_grant", 32'(log_g[k+6]), 32'h8);
    end
    check("t4_empty_gap", 32'(log_c[2] - log_c[1]), 32'd4);

    // One-word packet on source 3
    clear_srcs();
    push(3, 16'hA5A5, 1'b1);
    reset_dut();
    repeat (4) step();
    check("t5_count", 32'(n_log), 32'd1);
    check("t5_dout", 32'(log_d[0]), 32'hA5A5);
    check("t5_flags", 32'(log_f[0]), 32'h3);
    check("t5_grant", 32'(log_g[0]), 32'h8);

    // 10-word packet against an 8-word limit
    clear_srcs();
    load_pkt(0, 16'h3000, 10);
    reset_dut();
    repeat (20) step();
    check("t6_count", 32'(n_log), 32'd10);
    for (int k = 0; k < 10; k++) begin
      check("t6_word", 32'(log_d[k]), 32'h3000 + 32'(k));
      check("t6_grant", 32'(log_g[k]), 32'h1);
`ifdef OUTPKT_ARB_MAXLEN_CHECK_EN
      check("t6_flags", 32'(log_f[k]), 32'({k == 0 || k == 8, k == 7 || k == 9}));
`else
      check("t6_flags", 32'(log_f[k]), 32'({k == 0, k == 9}));
`endif
    end
`ifdef OUTPKT_ARB_MAXLEN_CHECK_EN
    check("t6_err", 32'(err), 32'h1);
    check("t6_split_gap", 32'(log_c[8] - log_c[7]), 32'd2);
`else
    check("t6_err", 32'(err), 32'h0);
`endif
    reset_dut();
    @(negedge CLK);
    check("t6_err_after_rst", 32'(err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/outpkt_arbiter.md
OUTPKT_ARBITER -- requirements
Module: outpkt_arbiter

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4, meaning number of packet sources (2..8).
REQ-002 The block SHALL have parameter MAX_WORDS, default 1024, meaning maximum packet length in 16-bit words, header included.
REQ-003 The block SHALL have port CLK  input  1  clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port src_din  input  16*N_SRC  word from source i on bits [16i+15:16i].
REQ-006 The block SHALL have port src_pkt_end  input  N_SRC  source i's current word is the last word of its packet.
REQ-007 The block SHALL have port src_empty  input  N_SRC  source i has no word available.
REQ-008 The block SHALL have port src_rd_en  output  N_SRC  pops the current word from source i.
REQ-009 The block SHALL have port dout  output  16  word to the checksum stage.
REQ-010 The block SHALL have port pkt_new  output  1  dout is the first word of a packet.
REQ-011 The block SHALL have port pkt_end  output  1  dout is the last word of a packet.
REQ-012 The block SHALL have port wr_en  output  1  dout/pkt_new/pkt_end valid and written this cycle.
REQ-013 The block SHALL have port full  input  1  checksum stage cannot accept a word.
REQ-014 The block SHALL have port grant  output  N_SRC  one-hot, registered; source owning the output.
REQ-015 The block SHALL have port err  output  1  sticky packet-too-long flag.

Function
REQ-016 The FSM SHALL have states IDLE and XFER.
REQ-017 In IDLE, if any src_empty bit is 0, it SHALL select the first non-empty source searching round-robin from last_grant+1 (mod N_SRC), register grant, clear word_cnt, set first_r=1, and enter XFER next cycle.
REQ-018 In IDLE, grant SHALL be 0 and wr_en/src_rd_en SHALL be 0.
REQ-019 In XFER with grant bit g, wr_en and src_rd_en[g] SHALL equal ~src_empty[g] & ~full, combinationally; all other src_rd_en bits SHALL be 0.
REQ-020 dout SHALL equal src_din of granted source combinationally, 0 in IDLE.
REQ-021 pkt_new SHALL equal wr_en & first_r; first_r SHALL clear on first wr_en of the packet.
REQ-022 pkt_end SHALL equal wr_en & (src_pkt_end[g] | forced end per REQ-030).
REQ-023 On wr_en & pkt_end, the block SHALL set last_grant=g and return to IDLE; the following cycle SHALL not transfer.
REQ-024 A one-word packet SHALL assert pkt_new and pkt_end in the same cycle.
REQ-025 full or src_empty[g] in XFER SHALL stall without losing grant; no other source SHALL interleave words mid-packet.
REQ-026 word_cnt (16 bits) SHALL increment on each wr_en in XFER, saturating at 65535.
REQ-027 Arbitration latency SHALL be 1 cycle: earliest first wr_en is the cycle after the IDLE decision.

Reset
REQ-028 On rst, state SHALL be IDLE, grant 0, last_grant N_SRC-1 (source 0 first), word_cnt 0, first_r 0, err 0; wr_en, pkt_new, pkt_end, src_rd_en SHALL be 0 that cycle and in IDLE thereafter.
REQ-029 rst mid-packet SHALL abandon the packet; the remaining source words are not discarded by this block.

Configuration
REQ-030 With OUTPKT_ARB_MAXLEN_CHECK_EN defined, a wr_en with word_cnt==MAX_WORDS-1 and src_pkt_end[g]=0 SHALL assert pkt_end, set err=1 (sticky until rst), and return to IDLE; the granted source's remaining words form a new packet later.
REQ-031 Without OUTPKT_ARB_MAXLEN_CHECK_EN, no length limit SHALL apply and err SHALL be constant 0.

Verification
REQ-032 After rst, sources 0 and 2 each hold a 6-word packet -> source 0 transfers first (grant=0001), then source 2 (grant=0100); pkt_new on words 1, pkt_end on words 6; 1 idle cycle between.
REQ-033 All 4 sources continuously non-empty, 3-word packets -> grant order 0,1,2,3,0; no source skipped.
REQ-034 full held high 5 cycles mid-packet -> wr_en=0, src_rd_en=0, grant unchanged; transfer resumes with next word, no duplicate or lost word.
REQ-035 Source 1 empty for 3 cycles mid-packet while source 3 non-empty -> no source-3 word until source 1 pkt_end.
REQ-036 One-word packet 0xA5A5 on source 3 -> single cycle wr_en=1, pkt_new=1, pkt_end=1, dout=0xA5A5.
REQ-037 With macro, MAX_WORDS=8, 10-word packet -> pkt_end on word 8, err=1; words 9-10 emitted as new packet with pkt_new; rst clears err.
